// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer that feeds a dual-issue decode stage.
//
// Accepts 64-bit fetch packets (two 32-bit instructions plus a per-half valid
// mask). Each valid half is stored in a circular buffer of DEPTH entries of
// {instr, pc}. The two oldest entries are presented to decode each cycle.
// Slots that hold no instruction drive instr=0 and pc=0, which decode treats
// as a flush bubble.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               redirect: empties the queue, drops same-cycle traffic
//   fetch_valid_i/_ready_o/_pc_i/_instr_i/_mask_i   fetch packet handshake
//   dec_instr0/1_o, dec_pc0/1_o, dec_valid0/1_o     decode slots (0 = oldest)
//   dec_take_i            number of slots decode consumes this cycle (0..2)
//   count_o               current occupancy
//
// Optional feature (macro FETCHQ_BYPASS_EN): when the queue is empty, an
// accepted packet is forwarded to the decode slots in the same cycle; only the
// entries decode does not take that cycle are written into storage.
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [PC_W-1:0]        fetch_pc_i,
  input  logic [63:0]            fetch_instr_i,
  input  logic [1:0]             fetch_mask_i,
  output logic [31:0]            dec_instr0_o,
  output logic [PC_W-1:0]        dec_pc0_o,
  output logic                   dec_valid0_o,
  output logic [31:0]            dec_instr1_o,
  output logic [PC_W-1:0]        dec_pc1_o,
  output logic                   dec_valid1_o,
  input  logic [1:0]             dec_take_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]     r_instr [DEPTH];
  logic [PC_W-1:0] r_pc    [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_enq;
  logic [1:0]      w_push_n;
  logic [31:0]     w_push_instr [2];
  logic [PC_W-1:0] w_push_pc    [2];
  logic            w_bypass;
  logic [CW-1:0]   w_avail;
  logic [1:0]      w_take;
  logic [1:0]      w_pop;
  logic [1:0]      w_skip;
  logic [1:0]      w_wr_n;
  logic [AW-1:0]   w_head1;

  // Ready depends on registered occupancy only, so a full packet always fits.
  assign fetch_ready_o = (r_count <= CW'(DEPTH - 2));
  assign w_enq         = fetch_valid_i && fetch_ready_o && !flush_i;
  assign count_o       = r_count;
  assign w_head1       = r_head + AW'(1);

  // Compact the valid halves into program order: entry 0 is the oldest.
  always_comb begin
    w_push_n        = {1'b0, fetch_mask_i[0]} + {1'b0, fetch_mask_i[1]};
    w_push_instr[0] = fetch_mask_i[0] ? fetch_instr_i[31:0] : fetch_instr_i[63:32];
    w_push_pc[0]    = fetch_mask_i[0] ? fetch_pc_i : fetch_pc_i + PC_W'(4);
    w_push_instr[1] = fetch_instr_i[63:32];
    w_push_pc[1]    = fetch_pc_i + PC_W'(4);
  end

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass = w_enq && (r_count == '0) && (w_push_n != 2'd0);
`else
  assign w_bypass = 1'b0;
`endif

  // Entries visible to decode this cycle: bypassed packet or stored entries.
  assign w_avail = w_bypass ? CW'(w_push_n) : r_count;

  always_comb begin
    w_take = (dec_take_i == 2'd3) ? 2'd2 : dec_take_i;
    if (CW'(w_take) > w_avail) begin
      w_pop = w_avail[1:0];
    end else begin
      w_pop = w_take;
    end
    // Bypassed entries taken by decode this cycle are never written.
    w_skip = w_bypass ? w_pop : 2'd0;
    w_wr_n = w_enq ? (w_push_n - w_skip) : 2'd0;
  end

  always_comb begin
    dec_valid0_o = 1'b0;
    dec_instr0_o = '0;
    dec_pc0_o    = '0;
    dec_valid1_o = 1'b0;
    dec_instr1_o = '0;
    dec_pc1_o    = '0;
    if (w_bypass) begin
      dec_valid0_o = 1'b1;
      dec_instr0_o = w_push_instr[0];
      dec_pc0_o    = w_push_pc[0];
      if (w_push_n == 2'd2) begin
        dec_valid1_o = 1'b1;
        dec_instr1_o = w_push_instr[1];
        dec_pc1_o    = w_push_pc[1];
      end
    end else begin
      if (r_count != '0) begin
        dec_valid0_o = 1'b1;
        dec_instr0_o = r_instr[r_head];
        dec_pc0_o    = r_pc[r_head];
      end
      if (r_count >= CW'(2)) begin
        dec_valid1_o = 1'b1;
        dec_instr1_o = r_instr[w_head1];
        dec_pc1_o    = r_pc[w_head1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Bypassed pops come straight from the packet, not from storage.
      r_head  <= r_head + (w_bypass ? AW'(0) : AW'(w_pop));
      r_tail  <= r_tail + AW'(w_wr_n);
      r_count <= r_count + (w_enq ? CW'(w_push_n) : CW'(0)) - CW'(w_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_n != 2'd0) begin
      r_instr[r_tail] <= w_push_instr[w_skip[0]];
      r_pc[r_tail]    <= w_push_pc[w_skip[0]];
    end
    if (w_wr_n == 2'd2) begin
      r_instr[r_tail + AW'(1)] <= w_push_instr[1];
      r_pc[r_tail + AW'(1)]    <= w_push_pc[1];
    end
  end

  // Decode must never take more than is visible, and never 3.
  a_take_legal: assert property (@(posedge clk) disable iff (!rst_n)
    !flush_i |-> ((dec_take_i != 2'd3) && (CW'(dec_take_i) <= w_avail)));

endmodule
